board_validate: RTL and testbench

Board-side responder for the piece lock-in handshake. On `validate_start` it writes the four blocks of the landed piece into the 10×20 playfield, then scans for full rows. Each full row is removed and everything above it shifts down one row. It then pulses `validate_done_flag` back to the game controller. The block owns the playfield storage and serves a combinational read port for the VGA path and the controller's collision queries.

---
 rtl/board_validate.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_board_validate.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_validate.sv
// Playfield owner for piece lock-in: writes the four blocks of a landed piece, then removes full rows.
// Latency: 20-cycle clear after reset; lock-in is 4 write cycles + one scan per row + (r+2) cycles per removed row + 1 done cycle.
// Backpressure: none; i_validate_start is taken only in IDLE (o_board_rdy=1), otherwise dropped with no queueing.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-low reset
//   i_validate_start        lock-in request, sampled only in IDLE
//   i_x0..i_x3 / i_y0..i_y3 absolute block coordinates (x>=COLS or y>=ROWS means "skip this block")
//   i_write_colour          colour written into every block of the piece
//   i_rd_x, i_rd_y          combinational read port address
//   o_rd_occupied/colour    read port data, 0 when out of range
//   o_board_rdy             idle with a cleared or valid board
//   o_write_done            1-cycle pulse, first scan cycle after the writes
//   o_validate_done_flag    1-cycle pulse, operation complete
//   o_lines_cleared         rows removed by the last operation
//   o_score                 accumulated score (only when BOARD_SCORE_EN is defined, otherwise 0)
//
// Optional feature: define BOARD_SCORE_EN to build the scoring accumulator.

module board_validate #(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_validate_start,
    input  logic [5:0]  i_x0,
    input  logic [5:0]  i_x1,
    input  logic [5:0]  i_x2,
    input  logic [5:0]  i_x3,
    input  logic [4:0]  i_y0,
    input  logic [4:0]  i_y1,
    input  logic [4:0]  i_y2,
    input  logic [4:0]  i_y3,
    input  logic [2:0]  i_write_colour,
    input  logic [3:0]  i_rd_x,
    input  logic [4:0]  i_rd_y,
    output logic        o_rd_occupied,
    output logic [2:0]  o_rd_colour,
    output logic        o_board_rdy,
    output logic        o_write_done,
    output logic        o_validate_done_flag,
    output logic [2:0]  o_lines_cleared,
    output logic [23:0] o_score
);

    localparam logic [5:0] COLS_X   = 6'(COLS);
    localparam logic [3:0] COLS_R   = 4'(COLS);
    localparam logic [4:0] ROWS_Y   = 5'(ROWS);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_WRITE,
        S_SCAN,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Playfield: one occupancy bit per cell, colour packed 3 bits per cell
    // so that whole rows move in a single assignment during SHIFT.
    logic [COLS-1:0]   r_occ [ROWS];
    logic [3*COLS-1:0] r_col [ROWS];

    logic [4:0] r_clr_row;
    logic [4:0] r_scan_row;
    logic [4:0] r_shift_row;
    logic [1:0] r_wr_idx;
    logic [5:0] r_bx [4];
    logic [4:0] r_by [4];
    logic [2:0] r_colour;
    logic       r_write_done;
    logic [2:0] r_lines;

    logic [5:0] w_blk_x;
    logic [4:0] w_blk_y;
    logic       w_blk_ok;
    logic [4:0] w_wr_lsb;
    logic       w_row_full;
    logic [4:0] w_shift_src;
    logic       w_rd_ok;
    logic [4:0] w_rd_lsb;

    // ------------------------------------------------------------------
    // Block selection and row test
    // ------------------------------------------------------------------
    always_comb begin
        w_blk_x     = r_bx[r_wr_idx];
        w_blk_y     = r_by[r_wr_idx];
        // Full 6-bit compare so x values 16..63 are rejected, not aliased.
        w_blk_ok    = (w_blk_x < COLS_X) && (w_blk_y < ROWS_Y);
        w_wr_lsb    = {1'b0, w_blk_x[3:0]} * 5'd3;
        w_row_full  = &r_occ[r_scan_row];
        w_shift_src = r_shift_row - 5'd1;
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_ok       = (i_rd_x < COLS_R) && (i_rd_y < ROWS_Y);
        w_rd_lsb      = {1'b0, i_rd_x} * 5'd3;
        o_rd_occupied = 1'b0;
        o_rd_colour   = 3'd0;
        if (w_rd_ok) begin
            o_rd_occupied = r_occ[i_rd_y][i_rd_x];
            o_rd_colour   = r_col[i_rd_y][w_rd_lsb +: 3];
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt          = r_state;
        o_board_rdy          = 1'b0;
        o_validate_done_flag = 1'b0;
        case (r_state)
            S_CLEAR: begin
                if (r_clr_row == LAST_ROW) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                o_board_rdy = 1'b1;
                if (i_validate_start) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (r_wr_idx == 2'd3) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_row_full) begin
                    w_state_nxt = S_SHIFT;
                end else if (r_scan_row == 5'd0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_SHIFT: begin
                if (r_shift_row == 5'd0) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_DONE: begin
                o_validate_done_flag = 1'b1;
                w_state_nxt          = S_IDLE;
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Playfield storage. Not reset directly: CLEAR zeroes it row by row.
    // Writes are suppressed on a reset edge so an aborted shift stops at once.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            case (r_state)
                S_CLEAR: begin
                    r_occ[r_clr_row] <= '0;
                    r_col[r_clr_row] <= '0;
                end
                S_WRITE: begin
                    if (w_blk_ok) begin
                        r_occ[w_blk_y][w_blk_x[3:0]]  <= 1'b1;
                        r_col[w_blk_y][w_wr_lsb +: 3] <= r_colour;
                    end
                end
                S_SHIFT: begin
                    if (r_shift_row != 5'd0) begin
                        r_occ[r_shift_row] <= r_occ[w_shift_src];
                        r_col[r_shift_row] <= r_col[w_shift_src];
                    end else begin
                        r_occ[0] <= '0;
                        r_col[0] <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers: counters, latched piece, status
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_clr_row    <= 5'd0;
            r_scan_row   <= 5'd0;
            r_shift_row  <= 5'd0;
            r_wr_idx     <= 2'd0;
            r_colour     <= 3'd0;
            r_write_done <= 1'b0;
            r_lines      <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                r_bx[i] <= 6'd0;
                r_by[i] <= 5'd0;
            end
        end else begin
            r_write_done <= 1'b0;
            case (r_state)
                S_CLEAR: begin
                    r_clr_row <= (r_clr_row == LAST_ROW) ? 5'd0 : r_clr_row + 5'd1;
                end
                S_IDLE: begin
                    if (i_validate_start) begin
                        r_bx[0]  <= i_x0;
                        r_bx[1]  <= i_x1;
                        r_bx[2]  <= i_x2;
                        r_bx[3]  <= i_x3;
                        r_by[0]  <= i_y0;
                        r_by[1]  <= i_y1;
                        r_by[2]  <= i_y2;
                        r_by[3]  <= i_y3;
                        r_colour <= i_write_colour;
                        r_lines  <= 3'd0;
                        r_wr_idx <= 2'd0;
                    end
                end
                S_WRITE: begin
                    r_wr_idx <= r_wr_idx + 2'd1;
                    if (r_wr_idx == 2'd3) begin
                        r_scan_row   <= LAST_ROW;
                        r_write_done <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (w_row_full) begin
                        r_shift_row <= r_scan_row;
                    end else if (r_scan_row != 5'd0) begin
                        r_scan_row <= r_scan_row - 5'd1;
                    end
                end
                S_SHIFT: begin
                    // Scan row is left alone so the row that just received
                    // the contents from above is tested again.
                    if (r_shift_row != 5'd0) begin
                        r_shift_row <= w_shift_src;
                    end else begin
                        r_lines <= r_lines + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_write_done    = r_write_done;
    assign o_lines_cleared = r_lines;

`ifdef BOARD_SCORE_EN
    logic [23:0] r_score;
    logic [23:0] w_score_add;
    logic [24:0] w_score_sum;

    always_comb begin
        case (r_lines)
            3'd0:    w_score_add = 24'd0;
            3'd1:    w_score_add = 24'd40;
            3'd2:    w_score_add = 24'd100;
            3'd3:    w_score_add = 24'd300;
            default: w_score_add = 24'd1200;
        endcase
        w_score_sum = {1'b0, r_score} + {1'b0, w_score_add};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_score <= 24'd0;
        end else if (r_state == S_DONE) begin
            // Carry out of bit 23 means the true sum passed 24'hFFFFFF.
            r_score <= w_score_sum[24] ? 24'hFFFFFF : w_score_sum[23:0];
        end
    end

    assign o_score = r_score;
`else
    assign o_score = 24'd0;
`endif

endmodule

// File: tb/tb_board_validate.sv
module tb_board_validate;

    logic        clk = 1'b0;
    logic        rst;
    logic        validate_start;
    logic [5:0]  x0, x1, x2, x3;
    logic [4:0]  y0, y1, y2, y3;
    logic [2:0]  write_colour;
    logic [3:0]  rd_x;
    logic [4:0]  rd_y;
    logic        rd_occupied;
    logic [2:0]  rd_colour;
    logic        board_rdy;
    logic        write_done;
    logic        validate_done_flag;
    logic [2:0]  lines_cleared;
    logic [23:0] score;

    int n_chk = 0;
    int n_err = 0;

`ifdef BOARD_SCORE_EN
    localparam int SCORE_ONE_LINE = 40;
    localparam int SCORE_TETRIS   = 1200;
`else
    localparam int SCORE_ONE_LINE = 0;
    localparam int SCORE_TETRIS   = 0;
`endif

    always #5 clk = ~clk;

    board_validate #(.COLS(10), .ROWS(20)) dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_validate_start     (validate_start),
        .i_x0                 (x0),
        .i_x1                 (x1),
        .i_x2                 (x2),
        .i_x3                 (x3),
        .i_y0                 (y0),
        .i_y1                 (y1),
        .i_y2                 (y2),
        .i_y3                 (y3),
        .i_write_colour       (write_colour),
        .i_rd_x               (rd_x),
        .i_rd_y               (rd_y),
        .o_rd_occupied        (rd_occupied),
        .o_rd_colour          (rd_colour),
        .o_board_rdy          (board_rdy),
        .o_write_done         (write_done),
        .o_validate_done_flag (validate_done_flag),
        .o_lines_cleared      (lines_cleared),
        .o_score              (score)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_piece(input logic [5:0] ax0, input logic [4:0] ay0,
                             input logic [5:0] ax1, input logic [4:0] ay1,
                             input logic [5:0] ax2, input logic [4:0] ay2,
                             input logic [5:0] ax3, input logic [4:0] ay3,
                             input logic [2:0] col);
        x0 = ax0; y0 = ay0;
        x1 = ax1; y1 = ay1;
        x2 = ax2; y2 = ay2;
        x3 = ax3; y3 = ay3;
        write_colour = col;
    endtask

    // Issues a start, then samples once per cycle; cycle k is the k-th cycle
    // after the start edge. Returns in the done cycle (or after the budget).
    // A non-zero glitch_k re-asserts start for one cycle at that point.
    task automatic run_op(input string tag, input int glitch_k, output int wd_at, output int done_at);
        validate_start = 1'b1;
        step();
        validate_start = 1'b0;
        wd_at   = 0;
        done_at = 0;
        for (int k = 1; k <= 300; k++) begin
            validate_start = (k == glitch_k);
            if (write_done === 1'b1 && wd_at == 0) wd_at = k;
            if (validate_done_flag === 1'b1) begin
                done_at = k;
                break;
            end
            step();
        end
        validate_start = 1'b0;
        check({tag, "_done_seen"}, 32'(done_at != 0), 1);
    endtask

    task automatic do_reset(input string tag);
        int rdy_at;
        int ndone;
        rst = 1'b0;
        validate_start = 1'b0;
        step();
        rst = 1'b1;
        check({tag, "_rst_vals"}, {write_done, validate_done_flag, lines_cleared, score}, 0);
        rdy_at = 0;
        ndone  = 0;
        for (int k = 1; k <= 40; k++) begin
            if (validate_done_flag === 1'b1) ndone++;
            if (board_rdy === 1'b1) begin
                rdy_at = k;
                break;
            end
            step();
        end
        check({tag, "_rdy_cycle"}, rdy_at, 21);
        check({tag, "_no_done"}, ndone, 0);
    endtask

    task automatic count_board(output int n);
        n = 0;
        for (int y = 0; y < 20; y++) begin
            for (int x = 0; x < 10; x++) begin
                rd_x = 4'(x);
                rd_y = 5'(y);
                #1;
                if (rd_occupied === 1'b1) n++;
            end
        end
    endtask

    task automatic check_cell(input string tag, input int x, input int y,
                              input logic occ, input logic [2:0] col);
        rd_x = 4'(x);
        rd_y = 5'(y);
        #1;
        check(tag, {rd_occupied, rd_colour}, {occ, col});
    endtask

    initial begin
        int wd;
        int dn;
        int n;
        int extra;

        rst = 1'b0;
        validate_start = 1'b0;
        rd_x = 4'd0;
        rd_y = 5'd0;
        set_piece(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Power-up clear
        do_reset("init");
        count_board(n);
        check("init_empty", n, 0);
        check_cell("rd_x_oob", 12, 3, 1'b0, 3'd0);
        check_cell("rd_y_oob", 2, 25, 1'b0, 3'd0);

        // Bottom-row piece, no row completes
        set_piece(0, 19, 1, 19, 2, 19, 3, 19, 3'd5);
        run_op("t1", 0, wd, dn);
        check("t1_write_done_cycle", wd, 5);
        check("t1_done_cycle", dn, 25);
        check("t1_lines", lines_cleared, 0);
        step();
        check("t1_rdy", board_rdy, 1);
        check_cell("t1_cell_2_19", 2, 19, 1'b1, 3'd5);
        check_cell("t1_cell_4_19", 4, 19, 1'b0, 3'd0);

        // Pre-fill cols 4,5 of row 19 and a marker at (0,18), then complete row 19
        set_piece(4, 19, 5, 19, 0, 18, 0, 18, 3'd2);
        run_op("t3_fill", 0, wd, dn);
        check("t3_fill_done_cycle", dn, 25);
        step();
        set_piece(6, 19, 7, 19, 8, 19, 9, 19, 3'd3);
        run_op("t3", 0, wd, dn);
        check("t3_done_cycle", dn, 46);
        check("t3_lines", lines_cleared, 1);
        step();
        check_cell("t3_marker_moved", 0, 19, 1'b1, 3'd2);
        check_cell("t3_row18_col0", 0, 18, 1'b0, 3'd0);
        count_board(n);
        check("t3_cell_count", n, 1);
        check("t3_score", score, SCORE_ONE_LINE);
        check("t3_lines_hold", lines_cleared, 1);

        // One block off the right edge (x=12) is skipped, timing unchanged
        set_piece(12, 5, 3, 5, 4, 5, 3, 4, 3'd6);
        run_op("t5", 0, wd, dn);
        check("t5_write_done_cycle", wd, 5);
        check("t5_done_cycle", dn, 25);
        check("t5_lines", lines_cleared, 0);
        step();
        check_cell("t5_cell_3_5", 3, 5, 1'b1, 3'd6);
        check_cell("t5_cell_4_5", 4, 5, 1'b1, 3'd6);
        check_cell("t5_cell_3_4", 3, 4, 1'b1, 3'd6);
        count_board(n);
        check("t5_cell_count", n, 4);
        check("t5_score", score, SCORE_ONE_LINE);

        // Start pulse during SCAN is dropped: one done pulse only
        set_piece(1, 19, 2, 19, 3, 19, 4, 19, 3'd1);
        run_op("t6a", 10, wd, dn);
        check("t6a_done_cycle", dn, 25);
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (validate_done_flag === 1'b1) extra++;
        end
        check("t6a_extra_done", extra, 0);
        set_piece(5, 19, 6, 19, 7, 19, 8, 19, 3'd4);
        run_op("t6b", 0, wd, dn);
        check("t6b_done_cycle", dn, 25);
        step();
        count_board(n);
        check("t6b_cell_count", n, 12);

        // Complete row 19 and reset in the middle of SHIFT
        set_piece(9, 19, 3, 3, 3, 2, 3, 1, 3'd7);
        validate_start = 1'b1;
        step();
        validate_start = 1'b0;
        extra = 0;
        for (int k = 1; k < 10; k++) begin
            if (validate_done_flag === 1'b1) extra++;
            step();
        end
        check("t6c_no_done_pre_reset", extra, 0);
        do_reset("t6c");
        count_board(n);
        check("t6c_board_empty", n, 0);

        // Rows 16..19 filled except column 9, then a vertical I completes all four
        for (int c = 0; c < 9; c++) begin
            set_piece(6'(c), 16, 6'(c), 17, 6'(c), 18, 6'(c), 19, 3'(c % 7 + 1));
            run_op("t4_fill", 0, wd, dn);
            check("t4_fill_done_cycle", dn, 25);
            step();
        end
        count_board(n);
        check("t4_prefill_count", n, 36);
        set_piece(9, 16, 9, 17, 9, 18, 9, 19, 3'd2);
        run_op("t4", 0, wd, dn);
        check("t4_done_cycle", dn, 109);
        check("t4_lines", lines_cleared, 4);
        step();
        count_board(n);
        check("t4_board_empty", n, 0);
        check("t4_score", score, SCORE_TETRIS);
        check("t4_rdy", board_rdy, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
